lane_receiver: RTL
==================

Name: lane_receiver

Overview:
RX-side counterpart of lane_controller. Takes per-lane decoded words (ctrl flag plus 64-bit payload) from the 64b/66b decoders and deskews the lanes in multi-lane mode. Un-stripes the words in lane order, strips ordered sets and rebuilds the AXI-Stream frame (valid/last/data) for the user side. Sits between the lane decoders and the RX AXI master; there is no backpressure, matching the TX side.

Parameters:
MAX_LINKS, 4, number of physical lanes.
DATA_W, 64, word width (equals AXI data width and decoder output width).
FIFO_DEPTH, 4, per-lane deskew FIFO depth in words (power of two).

Ports:
clk  in  1  lane clock.
rst_n  in  1  asynchronous active-low reset.
single_lane  in  1  1 = only lane lane_select is used; 0 = all MAX_LINKS lanes, striped.
lane_select  in  $clog2(MAX_LINKS)  active lane in single-lane mode.
lane_valid_in  in  MAX_LINKS  per-lane word strobe from the decoder.
ctrl_in  in  MAX_LINKS  1 = control block, 0 = data block.
data_in  in  MAX_LINKS x DATA_W  decoded payload per lane.
axi_valid  out  1  output word valid.
axi_last  out  1  last word of frame.
axi_data  out  DATA_W  output word.
ordered_set  out  ordered_sets_e  last ordered set consumed; held until the next one.
aligned  out  1  lanes deskewed, frames being delivered.
frame_err  out  1  one-cycle pulse on a framing error.
align_err  out  1  one-cycle pulse on loss of alignment or FIFO overflow.

Behaviour:
- Word classification: ctrl=0 is DATA. ctrl=1 is decoded by block type data[63:56]: BT_IDLE 0x78, BT_CB 0x79 (channel bond), BT_CC 0x7A (clock compensation), BT_SEP 0x1E (end of frame). Any other type is ignored and raises frame_err.
- TX striping is decided: consecutive words go to lanes 0,1,..,MAX_LINKS-1, then wrap. CB is sent on all lanes in the same striping slot.
- Reset: all outputs 0, ordered_set = IDLE, FIFOs empty, state HUNT, holding register empty.
- Per-lane FIFO: write on lane_valid_in when the lane is enabled. Write while full -> drop the word, pulse align_err, flush all FIFOs, go to HUNT.
- Alignment FSM, multi-lane:
  - HUNT: pop and discard each lane's head until it is CB. When all lane heads are CB in the same cycle, pop all of them, set rr=0 and go to ALIGNED.
  - ALIGNED: each cycle, if FIFO[rr] is non-empty, pop its head, process it, then rr = rr+1 mod MAX_LINKS.
  - A CB head at rr!=0 -> align_err, flush, HUNT. Any flush from ALIGNED also discards the holding register with no output.
- Single-lane: only FIFO[lane_select] is used; state is ALIGNED once the first word is popped; rr is unused. Changing single_lane or lane_select is only legal while in HUNT or after reset.
- aligned = (state == ALIGNED), registered.
- Deframing uses a one-word holding register (hold_v, hold_d):
  - Popped DATA with hold_v=1: emit hold_d with last=0 next cycle, then load the new word.
  - Popped DATA with hold_v=0: load only.
  - Popped SEP with hold_v=1: emit hold_d with last=1 and clear hold_v.
  - Popped SEP with hold_v=0: frame_err pulse, no output.
  - IDLE/CB/CC: update ordered_set, no output; the held word stays held, so ordered sets inside a frame are transparent.
- Latency: a FIFO write becomes the FIFO head one cycle later. A popped word reaches axi_* no earlier than the next DATA/SEP pop, plus 1 registered cycle. axi_valid is never high for two words in one cycle.
- Simultaneous write and pop on a full FIFO is legal and does not overflow.

Decomposition:
- aurora_pkg gains: the BT_* block-type constants (shared with the TX framer) and the alignment state enum {HUNT, ALIGNED}. The existing ordered_sets_e is reused.
- One sub-module, lane_deskew_fifo: single-clock FIFO, DATA_W+1 wide, with push, pop, flush, empty, full and overflow. Instantiated MAX_LINKS times.
- The top level holds the alignment FSM, the round-robin pointer and the deframer.

Test Plan:
- Single lane, lane_select=2: CB, DATA 0xDEADB00D_00000000, SEP on lane 2 -> one axi beat, data 0xDEADB00D_00000000, last=1; aligned=1; other lanes ignored.
- Multi-lane: CB on all 4 lanes, then DATA j=0..6 striped and SEP on lane 3 -> 7 beats in order j=0..6, only j=6 with last=1.
- Multi-lane skew: lane 1 delayed 2 cycles relative to lanes 0/2/3 -> output identical to the unskewed run; no align_err.
- IDLE and CC inserted mid-frame between DATA words -> frame unchanged; ordered_set shows CC after it is consumed.
- SEP with no preceding DATA -> frame_err single-cycle pulse, axi_valid stays 0.
- CB arriving at rr=2, or 5 writes into a stalled lane FIFO -> align_err pulse, aligned=0, held word discarded. Recovery after the next all-lane CB.
- rst_n low for 1 cycle mid-frame -> all outputs 0 asynchronously, state HUNT, no partial frame emitted afterwards.

Source files
------------

// File: rtl/aurora_pkg.sv
// aurora_pkg: block types, ordered sets and lane alignment states.
package aurora_pkg;
    typedef enum logic [1:0] {OS_IDLE, OS_CB, OS_CC} ordered_sets_e;
    typedef enum logic {HUNT, ALIGNED} align_state_e;
    localparam logic [7:0] BT_IDLE = 8'h78;
    localparam logic [7:0] BT_CB   = 8'h79;
    localparam logic [7:0] BT_CC   = 8'h7A;
    localparam logic [7:0] BT_SEP  = 8'h1E;
endpackage

// File: rtl/lane_rx_if.sv
// lane_rx_if: decoded lane words in, AXI-Stream words out.
interface lane_rx_if #(
    parameter int MAX_LINKS = 4,
    parameter int DATA_W    = 64
);
    logic [MAX_LINKS-1:0]             lane_valid_in;
    logic [MAX_LINKS-1:0]             ctrl_in;
    logic [MAX_LINKS-1:0][DATA_W-1:0] data_in;
    logic                             axi_valid;
    logic                             axi_last;
    logic [DATA_W-1:0]                axi_data;
    modport master(output lane_valid_in, ctrl_in, data_in, input axi_valid, axi_last, axi_data);
    modport slave(input lane_valid_in, ctrl_in, data_in, output axi_valid, axi_last, axi_data);
endinterface

// File: rtl/lane_deskew_fifo.sv
// lane_deskew_fifo: per-lane single-clock FIFO; a push while full is dropped and flagged.
module lane_deskew_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [AW:0]   cnt;
    logic          full, do_pop, do_push;
    assign empty    = cnt == '0;
    assign full     = cnt == (AW+1)'(DEPTH);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !pop;
    assign dout     = mem[rd];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else if (flush) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            rd  <= rd + AW'(do_pop);
            wr  <= wr + AW'(do_push);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push && !flush) mem[wr] <= din;
endmodule

// File: rtl/lane_receiver.sv
// lane_receiver: deskews striped lanes, strips ordered sets and rebuilds AXI-Stream frames.
module lane_receiver
    import aurora_pkg::*;
#(
    parameter int MAX_LINKS  = 4,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         single_lane,
    input  logic [$clog2(MAX_LINKS)-1:0] lane_select,
    lane_rx_if.slave                     lanes,
    output ordered_sets_e                ordered_set,
    output logic                         aligned,
    output logic                         frame_err,
    output logic                         align_err
);
    localparam int LW = $clog2(MAX_LINKS);
    localparam int W  = DATA_W + 1;
    logic [MAX_LINKS-1:0] pop, empty, ovf, hd_cb;
    logic [W-1:0]         hd [MAX_LINKS];
    logic [W-1:0]         cur;
    logic [LW-1:0]        idx, rr, rr_n;
    logic [7:0]           bt;
    logic                 flush, mis, proc, hold_v;
    logic [DATA_W-1:0]    hold_d;
    align_state_e         state, state_n;
    for (genvar i = 0; i < MAX_LINKS; i++) begin : g_lane
        lane_deskew_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (lanes.lane_valid_in[i] && (!single_lane || lane_select == LW'(i))),
            .pop      (pop[i]),
            .flush    (flush),
            .din      ({lanes.ctrl_in[i], lanes.data_in[i]}),
            .dout     (hd[i]),
            .empty    (empty[i]),
            .overflow (ovf[i])
        );
        assign hd_cb[i] = !empty[i] && hd[i][DATA_W] && hd[i][DATA_W-1 -: 8] == BT_CB;
    end
    assign idx   = single_lane ? lane_select : rr;
    assign cur   = hd[idx];
    assign bt    = cur[DATA_W-1 -: 8];
    assign flush = mis || |ovf;
    // Pops never depend on overflow, so the FIFO overflow flags stay loop-free.
    always_comb begin
        pop     = '0;
        proc    = 1'b0;
        mis     = 1'b0;
        rr_n    = rr;
        state_n = state;
        if (single_lane) begin
            if (!empty[idx]) begin
                pop[idx] = 1'b1;
                proc     = 1'b1;
                state_n  = ALIGNED;
            end
        end else if (state == HUNT) begin
            if (&hd_cb) begin
                pop     = '1;
                proc    = 1'b1;
                rr_n    = '0;
                state_n = ALIGNED;
            end else pop = ~empty & ~hd_cb;
        end else if (!empty[idx]) begin
            if (!hd_cb[idx]) begin
                pop[idx] = 1'b1;
                proc     = 1'b1;
                rr_n     = rr == LW'(MAX_LINKS - 1) ? '0 : rr + LW'(1);
            end else if (rr != '0) mis = 1'b1;
            else if (&hd_cb) begin
                pop  = '1;
                proc = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state           <= HUNT;
            rr              <= '0;
            aligned         <= 1'b0;
            hold_v          <= 1'b0;
            hold_d          <= '0;
            lanes.axi_valid <= 1'b0;
            lanes.axi_last  <= 1'b0;
            lanes.axi_data  <= '0;
            ordered_set     <= OS_IDLE;
            frame_err       <= 1'b0;
            align_err       <= 1'b0;
        end else begin
            state           <= flush ? HUNT : state_n;
            rr              <= rr_n;
            aligned         <= !flush && state_n == ALIGNED;
            align_err       <= flush;
            lanes.axi_valid <= 1'b0;
            lanes.axi_last  <= 1'b0;
            frame_err       <= 1'b0;
            if (flush) hold_v <= 1'b0;
            else if (proc && !cur[DATA_W]) begin
                lanes.axi_valid <= hold_v;
                lanes.axi_data  <= hold_d;
                hold_d          <= cur[DATA_W-1:0];
                hold_v          <= 1'b1;
            end else if (proc && bt == BT_SEP) begin
                lanes.axi_valid <= hold_v;
                lanes.axi_last  <= hold_v;
                lanes.axi_data  <= hold_d;
                frame_err       <= !hold_v;
                hold_v          <= 1'b0;
            end else if (proc) begin
                if (bt == BT_IDLE || bt == BT_CB || bt == BT_CC)
                    ordered_set <= bt == BT_CB ? OS_CB : bt == BT_CC ? OS_CC : OS_IDLE;
                else frame_err <= 1'b1;
            end
        end
endmodule
